dma_copy_master: RTL and testbench
==================================

# dma_copy_master

Single-channel DMA copy initiator for the microprocessor's DMA module. Drives the read-enable and write-enable strobe side of the register protocol, where a register captures data on a write strobe and presents it one clock later on a read strobe. Moves a programmed number of 32-bit words from a source register window to a destination register window, one word at a time, then reports completion. Sits between the CPU-side DMA control registers and the register-bank address/strobe bus.

## Interface
- DATA_W, 32, word width
- ADDR_W, 8, register-bank address width
- CNT_W, 8, transfer-length width
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- src_base  in  ADDR_W  first source address, captured at start
- dst_base  in  ADDR_W  first destination address, captured at start
- length  in  CNT_W  number of words, captured at start
- rd_en  out  1  read strobe to source register (ENrd-side)
- rd_addr  out  ADDR_W  source address
- rd_data  in  DATA_W  source data, valid the cycle after rd_en
- wr_en  out  1  write strobe to destination register (ENwr-side)
- wr_addr  out  ADDR_W  destination address
- wr_data  out  DATA_W  data written
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- abort  in  1  present only with DMA_ABORT_EN

## Operation
- Reset: all outputs 0; state IDLE; internal address/count registers 0.
- States: IDLE, READ, WAIT, WRITE, DONE.
- IDLE: on start=1, capture src_base, dst_base, length; length=0 -> DONE, else -> READ.
- READ: rd_en=1, rd_addr=current source address; -> WAIT.
- WAIT: rd_en=0; rd_data sampled into data holding register at end of cycle; -> WRITE.
- WRITE: wr_en=1, wr_addr=current destination address, wr_data=held word; both addresses +1, remaining count -1; remaining became 0 -> DONE, else -> READ.
- DONE: done=1 for exactly one cycle; -> IDLE.
- busy=1 in READ, WAIT, WRITE, DONE; 0 in IDLE.
- Addresses increment modulo 2^ADDR_W (0xFF -> 0x00 wraps silently).
- rd_en and wr_en never asserted in the same cycle.
- start while busy: ignored, no capture, no effect on current transfer.
- Inputs src_base/dst_base/length changing mid-transfer: no effect.
- rst asserted in any state: next cycle IDLE, all outputs 0, transfer discarded, no done.

## Timing
- start sampled at edge 0 -> READ during cycle 1 (rd_en high).
- Each word: 3 cycles (READ, WAIT, WRITE).
- Length N>0: busy high 3N+1 cycles; done during cycle 3N+1 after start edge.
- Length 0: busy and done high for one cycle, cycle 1.
- New start accepted earliest the cycle after DONE (back-to-back gap of one IDLE cycle).
- Outputs are registered-state decodes; no combinational path from inputs to rd_en/wr_en.

## Configuration
- DMA_ABORT_EN defined: abort port exists; abort=1 in READ/WAIT/WRITE -> DONE next cycle, pending WRITE not issued, done pulses; abort in IDLE/DONE ignored.
- DMA_ABORT_EN undefined: no abort port; transfers always run to completion.

## Structure
- Shared package dma_pkg: state enum (IDLE, READ, WAIT, WRITE, DONE), default DATA_W/ADDR_W/CNT_W constants.
- One sub-module: dma_addr_counter (loadable, wrap-around incrementer), instantiated twice for source and destination addresses.

## Test plan
- length=3, src_base=0x10, dst_base=0x40, source holds 0xA0,0xA1,0xA2 -> writes 0x40=0xA0, 0x41=0xA1, 0x42=0xA2; done at cycle 10; busy 10 cycles.
- length=0 -> no rd_en/wr_en; busy and done high cycle 1 only.
- src_base=0xFE, dst_base=0xFF, length=3 -> reads 0xFE,0xFF,0x00; writes 0xFF,0x00,0x01.
- start pulsed again at cycle 4 of length-2 transfer -> ignored; exactly 2 writes, one done.
- rst at cycle 5 of length-4 transfer -> next cycle busy=0, rd_en=wr_en=0, no done; fresh start then completes normally.
- DMA_ABORT_EN: abort during second WAIT of length-4 -> one write only, done next cycle, then IDLE.

Source files
------------

// File: rtl/dma_pkg.sv
// dma_pkg
// Shared definitions for the DMA copy initiator: default word, address and
// transfer-length widths, plus the FSM state encoding used by dma_copy_master.
// No ports (package only).
package dma_pkg;

  localparam int DMA_DATA_W = 32;
  localparam int DMA_ADDR_W = 8;
  localparam int DMA_CNT_W  = 8;

  localparam int STATE_W = 3;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_READ  = 3'd1;
  localparam state_t ST_WAIT  = 3'd2;
  localparam state_t ST_WRITE = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

endpackage

// File: rtl/dma_addr_counter.sv
// dma_addr_counter
// Loadable address register that increments by one and wraps silently from
// all-ones back to zero. Used once for the source window and once for the
// destination window of the copy.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset, clears the address
//   load     in   load load_val this cycle (has priority over inc)
//   load_val in   ADDR_W  value to load
//   inc      in   advance the address by one
//   addr     out  ADDR_W  current address
module dma_addr_counter #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr
);

  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
    end else if (load) begin
      addr <= load_val;
    end else if (inc) begin
      addr <= addr + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/dma_copy_master.sv
// dma_copy_master
// Single-channel DMA copy initiator. Copies `length` words from a source
// register window to a destination register window, one word per
// READ -> WAIT -> WRITE sequence, then pulses done for one cycle.
// The register protocol presents read data one clock after the read strobe,
// so the word is captured at the end of WAIT and written out in WRITE.
//
// Optional feature: define DMA_ABORT_EN to add the abort input. An abort in
// READ/WAIT/WRITE skips to DONE on the next cycle (no further writes).
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   start     in   one-cycle request, only honoured in IDLE
//   src_base  in   ADDR_W  first source address (captured at start)
//   dst_base  in   ADDR_W  first destination address (captured at start)
//   length    in   CNT_W   word count (captured at start)
//   rd_en     out  read strobe
//   rd_addr   out  ADDR_W  source address
//   rd_data   in   DATA_W  source data, valid the cycle after rd_en
//   wr_en     out  write strobe
//   wr_addr   out  ADDR_W  destination address
//   wr_data   out  DATA_W  word written
//   busy      out  transfer in progress
//   done      out  one-cycle completion pulse
//   abort     in   (DMA_ABORT_EN only) cancel the running transfer
module dma_copy_master
  import dma_pkg::*;
#(
  parameter int DATA_W = DMA_DATA_W,
  parameter int ADDR_W = DMA_ADDR_W,
  parameter int CNT_W  = DMA_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [CNT_W-1:0]  length,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done
`ifdef DMA_ABORT_EN
  ,
  input  logic              abort
`endif
);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  rem_cnt;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [DATA_W-1:0] rd_data_p1;
  logic              accept;
  logic              in_xfer;
  logic              abort_req;

  assign accept  = (state == ST_IDLE) && start;
  assign in_xfer = (state == ST_READ) || (state == ST_WAIT) || (state == ST_WRITE);

`ifdef DMA_ABORT_EN
  assign abort_req = abort && in_xfer;
`else
  assign abort_req = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = (length == '0) ? ST_DONE : ST_READ;
      ST_READ:  state_nxt = ST_WAIT;
      ST_WAIT:  state_nxt = ST_WRITE;
      ST_WRITE: state_nxt = (rem_cnt == CNT_W'(1)) ? ST_DONE : ST_READ;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (abort_req) state_nxt = ST_DONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      rem_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rem_cnt <= length;
      end else if (state == ST_WRITE) begin
        rem_cnt <= rem_cnt - CNT_W'(1);
      end
    end
  end

  dma_addr_counter #(.ADDR_W(ADDR_W)) u_src_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (src_base),
    .inc      (state == ST_WRITE),
    .addr     (src_addr)
  );

  dma_addr_counter #(.ADDR_W(ADDR_W)) u_dst_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (dst_base),
    .inc      (state == ST_WRITE),
    .addr     (dst_addr)
  );

  // Stage p1: source word captured at the end of WAIT, one clock after rd_en.
  // Not reset: it is only observed through wr_data, which is gated by WRITE.
  always_ff @(posedge clk) begin
    if (state == ST_WAIT) begin
      rd_data_p1 <= rd_data;
    end
  end

  // Outputs are pure decodes of registered state; address/data buses read
  // zero whenever their strobe is low.
  assign rd_en   = (state == ST_READ);
  assign wr_en   = (state == ST_WRITE);
  assign rd_addr = rd_en ? src_addr : '0;
  assign wr_addr = wr_en ? dst_addr : '0;
  assign wr_data = wr_en ? rd_data_p1 : '0;
  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);

endmodule

// File: tb/tb_dma_copy_master.sv
module tb_dma_copy_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  src_base = '0;
  logic [7:0]  dst_base = '0;
  logic [7:0]  length = '0;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data = '0;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
`ifdef DMA_ABORT_EN
  logic        abort = 1'b0;
  int          abort_cyc = -1;
`endif

  dma_copy_master #(.DATA_W(32), .ADDR_W(8), .CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .src_base (src_base),
    .dst_base (dst_base),
    .length   (length),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done)
`ifdef DMA_ABORT_EN
    ,
    .abort    (abort)
`endif
  );

  always #5 clk = ~clk;

  // Source register bank: data appears the cycle after the read strobe.
  logic [31:0] src_mem [256];
  always @(posedge clk) if (rd_en) rd_data <= src_mem[rd_addr];

  int checks = 0;
  int errors = 0;

  int c, busy_cyc, done_cyc, done_cnt, rd_cnt, wr_cnt, overlap, timeout;
  logic        first_rd_en;
  logic [7:0]  first_rd_addr;
  logic        last_busy, last_rd, last_wr, last_done;
  logic [7:0]  rd_log   [16];
  logic [7:0]  wr_alog  [16];
  logic [31:0] wr_dlog  [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a transfer at edge 0 and watch it cycle by cycle until busy drops.
  // restart_cyc / rst_cyc: cycle in which start / rst is held high (-1 = never).
  task automatic run(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n,
                     input int restart_cyc, input int rst_cyc);
    int limit;
    busy_cyc = 0; done_cyc = -1; done_cnt = 0; rd_cnt = 0; wr_cnt = 0;
    overlap = 0; timeout = 0;
    for (int k = 0; k < 16; k++) begin
      rd_log[k] = '0; wr_alog[k] = '0; wr_dlog[k] = '0;
    end
    src_base = s; dst_base = d; length = n; start = 1'b1;
    tick();
    start = 1'b0;
    // Inputs wander during the transfer; the captured values must hold.
    src_base = ~s; dst_base = ~d; length = n + 8'd3;
    c = 1;
    limit = 3 * int'(n) + 8;
    forever begin
      if (c == 1) begin first_rd_en = rd_en; first_rd_addr = rd_addr; end
      if (busy) busy_cyc++;
      if (done) begin done_cnt++; done_cyc = c; end
      if (rd_en) begin
        if (rd_cnt < 16) rd_log[rd_cnt] = rd_addr;
        rd_cnt++;
      end
      if (wr_en) begin
        if (wr_cnt < 16) begin wr_alog[wr_cnt] = wr_addr; wr_dlog[wr_cnt] = wr_data; end
        wr_cnt++;
      end
      if (rd_en && wr_en) overlap++;
      if (!busy) break;
      if (c >= limit) begin timeout = 1; break; end
      start = (c == restart_cyc);
      rst   = (c == rst_cyc);
`ifdef DMA_ABORT_EN
      abort = (c == abort_cyc);
`endif
      tick();
      c++;
    end
    start = 1'b0;
    rst   = 1'b0;
`ifdef DMA_ABORT_EN
    abort = 1'b0;
`endif
    last_busy = busy; last_rd = rd_en; last_wr = wr_en; last_done = done;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) src_mem[i] = 32'hD000_0000 | 32'(i);
    src_mem[8'h10] = 32'hA0;
    src_mem[8'h11] = 32'hA1;
    src_mem[8'h12] = 32'hA2;

    // Reset state
    rst = 1'b1;
    tick(); tick();
    check("rst_busy",    32'(busy),    32'h0);
    check("rst_done",    32'(done),    32'h0);
    check("rst_rd_en",   32'(rd_en),   32'h0);
    check("rst_wr_en",   32'(wr_en),   32'h0);
    check("rst_rd_addr", 32'(rd_addr), 32'h0);
    check("rst_wr_addr", 32'(wr_addr), 32'h0);
    check("rst_wr_data", wr_data,      32'h0);
    rst = 1'b0;
    tick();

    // Length 3, 0x10 -> 0x40
    run(8'h10, 8'h40, 8'd3, -1, -1);
    check("t1_timeout",   32'(timeout),       32'h0);
    check("t1_first_rd",  32'(first_rd_en),   32'h1);
    check("t1_first_adr", 32'(first_rd_addr), 32'h10);
    check("t1_done_cyc",  32'(done_cyc),      32'd10);
    check("t1_busy_cyc",  32'(busy_cyc),      32'd10);
    check("t1_done_cnt",  32'(done_cnt),      32'd1);
    check("t1_rd_cnt",    32'(rd_cnt),        32'd3);
    check("t1_wr_cnt",    32'(wr_cnt),        32'd3);
    check("t1_overlap",   32'(overlap),       32'd0);
    check("t1_wa0", 32'(wr_alog[0]), 32'h40);
    check("t1_wa1", 32'(wr_alog[1]), 32'h41);
    check("t1_wa2", 32'(wr_alog[2]), 32'h42);
    check("t1_wd0", wr_dlog[0], 32'hA0);
    check("t1_wd1", wr_dlog[1], 32'hA1);
    check("t1_wd2", wr_dlog[2], 32'hA2);
    check("t1_idle_out", {28'h0, last_busy, last_rd, last_wr, last_done}, 32'h0);

    // Length 0: only a one-cycle DONE
    tick();
    run(8'h22, 8'h33, 8'd0, -1, -1);
    check("t0_timeout",  32'(timeout),  32'h0);
    check("t0_rd_cnt",   32'(rd_cnt),   32'd0);
    check("t0_wr_cnt",   32'(wr_cnt),   32'd0);
    check("t0_busy_cyc", 32'(busy_cyc), 32'd1);
    check("t0_done_cyc", 32'(done_cyc), 32'd1);
    check("t0_done_cnt", 32'(done_cnt), 32'd1);

    // Address wrap-around
    tick();
    run(8'hFE, 8'hFF, 8'd3, -1, -1);
    check("wr_timeout", 32'(timeout),    32'h0);
    check("wr_ra0", 32'(rd_log[0]),  32'hFE);
    check("wr_ra1", 32'(rd_log[1]),  32'hFF);
    check("wr_ra2", 32'(rd_log[2]),  32'h00);
    check("wr_wa0", 32'(wr_alog[0]), 32'hFF);
    check("wr_wa1", 32'(wr_alog[1]), 32'h00);
    check("wr_wa2", 32'(wr_alog[2]), 32'h01);
    check("wr_wd0", wr_dlog[0], 32'hD000_00FE);
    check("wr_wd2", wr_dlog[2], 32'hD000_0000);

    // start pulsed again in cycle 4 of a length-2 transfer
    tick();
    run(8'h30, 8'h50, 8'd2, 4, -1);
    check("rs_timeout",  32'(timeout),    32'h0);
    check("rs_wr_cnt",   32'(wr_cnt),     32'd2);
    check("rs_done_cnt", 32'(done_cnt),   32'd1);
    check("rs_done_cyc", 32'(done_cyc),   32'd7);
    check("rs_wa1",      32'(wr_alog[1]), 32'h51);
    check("rs_wd1",      wr_dlog[1],      32'hD000_0031);
    tick();
    check("rs_stay_idle", 32'(busy), 32'h0);

    // rst in cycle 5 of a length-4 transfer
    tick();
    run(8'h10, 8'h40, 8'd4, -1, 5);
    check("rr_timeout",  32'(timeout),   32'h0);
    check("rr_stop_cyc", 32'(c),         32'd6);
    check("rr_outputs",  {28'h0, last_busy, last_rd, last_wr, last_done}, 32'h0);
    check("rr_done_cnt", 32'(done_cnt),  32'd0);
    check("rr_wr_cnt",   32'(wr_cnt),    32'd1);
    tick();
    run(8'h20, 8'h60, 8'd2, -1, -1);
    check("rf_timeout",  32'(timeout),    32'h0);
    check("rf_done_cyc", 32'(done_cyc),   32'd7);
    check("rf_wr_cnt",   32'(wr_cnt),     32'd2);
    check("rf_wa0",      32'(wr_alog[0]), 32'h60);
    check("rf_wd1",      wr_dlog[1],      32'hD000_0021);

`ifdef DMA_ABORT_EN
    // abort during the second WAIT (cycle 5) of a length-4 transfer
    tick();
    abort_cyc = 5;
    run(8'h10, 8'h40, 8'd4, -1, -1);
    abort_cyc = -1;
    check("ab_timeout",  32'(timeout),  32'h0);
    check("ab_wr_cnt",   32'(wr_cnt),   32'd1);
    check("ab_done_cyc", 32'(done_cyc), 32'd6);
    check("ab_done_cnt", 32'(done_cnt), 32'd1);
    check("ab_busy_cyc", 32'(busy_cyc), 32'd6);
    check("ab_idle",     32'(last_busy), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
